// File: rtl/inst_fetch_buffer.sv
// Circular instruction buffer between dual fetch and dispatch/rename.
// Two-wide push at tail, two-wide pop at head, single-cycle flush.
module inst_fetch_buffer #(
    parameter int DEPTH = 8,
    parameter int ADDR_W = 3,
    localparam int ENTRY_W = 106
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid1,
    input  logic               in_valid2,
    input  logic [ENTRY_W-1:0] in_entry1,
    input  logic [ENTRY_W-1:0] in_entry2,
    output logic               in_ready,
    output logic               out_valid1,
    output logic               out_valid2,
    output logic [ENTRY_W-1:0] out_entry1,
    output logic [ENTRY_W-1:0] out_entry2,
    input  logic               pop1,
    input  logic               pop2,
    output logic [ADDR_W:0]    count,
    output logic               protocol_err
);
    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [ADDR_W:0]   cnt_t;

    logic [ENTRY_W-1:0] mem [DEPTH];

    ptr_t head, tail;
    ptr_t head1, tail1;
    logic push1_ok, push2_ok;
    logic pop1_ok, pop2_ok;
    cnt_t npush, npop;
    logic err_next;

    // Pointer arithmetic relies on DEPTH == 2**ADDR_W so ptr_t wraps naturally.
    assign head1 = head + ptr_t'(1);
    assign tail1 = tail + ptr_t'(1);

    // Space check uses registered count only; a same-cycle pop never frees room.
    assign in_ready   = (count <= cnt_t'(DEPTH - 2));
    assign out_valid1 = (count != '0);
    assign out_valid2 = (count >= cnt_t'(2));
    assign out_entry1 = mem[head];
    assign out_entry2 = mem[head1];

    always_comb begin
        push1_ok = in_valid1 & in_ready;
        push2_ok = push1_ok & in_valid2;
        pop1_ok  = pop1 & out_valid1;
        pop2_ok  = pop1_ok & pop2 & out_valid2;
        npush    = cnt_t'(push1_ok) + cnt_t'(push2_ok);
        npop     = cnt_t'(pop1_ok) + cnt_t'(pop2_ok);
        err_next = (in_valid1 & ~in_ready)
                 | (in_valid2 & ~in_valid1)
                 | (pop1 & ~out_valid1)
                 | (pop2 & (~pop1 | ~out_valid2));
    end

    // Storage is intentionally not reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push1_ok) mem[tail]  <= in_entry1;
            if (push2_ok) mem[tail1] <= in_entry2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            protocol_err <= 1'b0;
        end else if (flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            protocol_err <= 1'b0;
        end else begin
            head         <= head + ptr_t'(npop);
            tail         <= tail + ptr_t'(npush);
            count        <= count + npush - npop;
            protocol_err <= err_next;
        end
    end
endmodule
